axi_bootrom_responder: RTL and testbench
========================================

Name: axi_bootrom_responder

Overview:
- AXI4 subordinate (responder) serving the read-only Boot ROM execute region at 0x1_0000, length 0x1_0000, to the CVA6 AXI initiator.
- Converts AR bursts into single-word requests to a synchronous ROM macro and returns R beats.
- Accepts and drains every write burst, then answers it with SLVERR.
- Sits on the SoC AXI crossbar behind an ATOP filter, so it never receives atomic operations.

Parameters:
AddrWidth, 64, AXI address width
DataWidth, 64, AXI data width; only 64 is supported
IdWidth, 4, AXI ID width
RomBase, 64'h1_0000, byte base address of the ROM region
RomSize, 64'h1_0000, ROM size in bytes; must be a power of two and a multiple of 8
RomAddrBits, 13, ROM word-address width, log2(RomSize/8)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ar_valid_i / ar_ready_o  in/out  1  AR handshake
ar_id_i  in  IdWidth  read ID
ar_addr_i  in  AddrWidth  burst start byte address
ar_len_i  in  8  beats minus 1
ar_size_i  in  3  log2 bytes per beat
ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
r_valid_o / r_ready_i  out/in  1  R handshake
r_id_o  out  IdWidth  echoed AR ID
r_data_o  out  DataWidth  read data
r_resp_o  out  2  00 OKAY, 10 SLVERR
r_last_o  out  1  final beat
aw_valid_i / aw_ready_o  in/out  1  AW handshake
aw_id_i  in  IdWidth  write ID
w_valid_i / w_ready_o  in/out  1  W handshake; data and strobe are ignored
w_last_i  in  1  final W beat
b_valid_o / b_ready_i  out/in  1  B handshake
b_id_o  out  IdWidth  echoed AW ID
b_resp_o  out  2  always 10 (SLVERR)
rom_req_o  out  1  ROM read strobe
rom_addr_o  out  RomAddrBits  ROM word address
rom_rdata_i  in  DataWidth  ROM data; valid the cycle after rom_req_o and held until the next rom_req_o

Behaviour:
- Reset: rst_ni low asynchronously forces both FSMs to IDLE and clears all registers. All outputs reset to 0 except ar_ready_o=1 and aw_ready_o=1. A reset mid-burst abandons the burst with no further beats or responses.
- The read FSM and write FSM are fully independent, and each holds only one transaction at a time.
- Read FSM R_IDLE:
  - ar_ready_o=1.
  - On an AR handshake, latch id, addr, len, size and burst, clear the beat count, and go to R_REQ.
  - The latched burst is flagged bad if ar_burst_i is WRAP or reserved (11), or if ar_size_i>3.
- Read FSM R_REQ (one cycle):
  - A beat is in range iff RomBase <= beat address <= RomBase+RomSize-8.
  - If the burst is good and the beat is in range: rom_req_o=1 and rom_addr_o=(beat address - RomBase)>>3.
  - Otherwise rom_req_o=0 and the beat is marked error.
  - Always go to R_SEND.
- Read FSM R_SEND:
  - r_valid_o=1 and r_id_o=latched id.
  - r_data_o=rom_rdata_i and r_resp_o=OKAY, or for an error beat r_data_o=0 and r_resp_o=SLVERR.
  - r_last_o=1 iff beat count equals len.
  - All R outputs stay stable until r_ready_i.
  - On a handshake: if last, go to R_IDLE; else increment the beat count, update the address, and go to R_REQ.
- Address update:
  - FIXED: unchanged.
  - INCR: align down to size, then add 1<<size; wrap modulo 2^AddrWidth.
  - Sub-word beats return the full aligned 64-bit word, and the initiator selects the lanes.
- Read latency:
  - AR handshake in cycle t gives r_valid_o in t+2.
  - An R handshake in cycle u gives the next r_valid_o in u+2, so throughput is one beat per 2 cycles.
  - A burst that crosses the region end returns OKAY for in-range beats and SLVERR for the rest, with the exact beat count still delivered.
- Write FSM W_IDLE:
  - aw_ready_o=1.
  - On an AW handshake, latch the id and go to W_DRAIN.
  - W beats presented before the AW handshake are not accepted (w_ready_o=0).
- Write FSM W_DRAIN:
  - w_ready_o=1 and every W beat is accepted.
  - The W handshake with w_last_i=1 moves to W_RESP.
- Write FSM W_RESP:
  - b_valid_o=1, b_id_o=latched id, b_resp_o=SLVERR, held until b_ready_i.
  - Then go to W_IDLE, with aw_ready_o=1 in the following cycle.
- A simultaneous AR and AW in the same cycle are both accepted, and each completes independently.

Test Plan:
1. AR id=3 addr=0x1_0000 len=3 size=3 INCR, ROM word k = 0xA5A5_0000_0000_000k, r_ready_i=1 -> rom_addr 0,1,2,3; R data k=0..3, OKAY, id=3; r_last only on the 4th beat; first r_valid 2 cycles after AR.
2. AR addr=0x1_FFF0 len=3 INCR size=3 -> beats 0 and 1 OKAY with ROM words 0x1FFE and 0x1FFF; beats 2 and 3 SLVERR with data 0; exactly 4 beats.
3. AR addr=0x8000_0000 len=0 -> a single beat, SLVERR, r_last=1, no rom_req_o. A separate AR with burst=WRAP and len=1 -> 2 SLVERR beats.
4. AR FIXED addr=0x1_0008 len=2 with r_ready_i low for 5 cycles on beat 1 -> rom_addr stays 1; r_data and r_last remain stable while stalled; 3 beats total.
5. AW id=9 followed by 4 W beats, b_ready_i held low 3 cycles, with a concurrent AR burst -> B id=9 SLVERR stable until accepted; the read burst is unaffected.
6. rst_ni asserted during beat 2 of a len=7 read -> r_valid_o=0 immediately; after release ar_ready_o=1 and a new burst returns correct data from beat 0.

Source files
------------

// File: rtl/axi_bootrom_responder_if.sv
// AXI4 read/write channel subset plus the synchronous ROM port used by the boot ROM responder.
interface axi_bootrom_responder_if #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned RomAddrBits = 13
);
    logic                   ar_valid_i;
    logic                   ar_ready_o;
    logic [IdWidth-1:0]     ar_id_i;
    logic [AddrWidth-1:0]   ar_addr_i;
    logic [7:0]             ar_len_i;
    logic [2:0]             ar_size_i;
    logic [1:0]             ar_burst_i;

    logic                   r_valid_o;
    logic                   r_ready_i;
    logic [IdWidth-1:0]     r_id_o;
    logic [DataWidth-1:0]   r_data_o;
    logic [1:0]             r_resp_o;
    logic                   r_last_o;

    logic                   aw_valid_i;
    logic                   aw_ready_o;
    logic [IdWidth-1:0]     aw_id_i;

    logic                   w_valid_i;
    logic                   w_ready_o;
    logic                   w_last_i;

    logic                   b_valid_o;
    logic                   b_ready_i;
    logic [IdWidth-1:0]     b_id_o;
    logic [1:0]             b_resp_o;

    logic                   rom_req_o;
    logic [RomAddrBits-1:0] rom_addr_o;
    logic [DataWidth-1:0]   rom_rdata_i;

    modport slave (
        input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
        output ar_ready_o,
        output r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
        input  r_ready_i,
        input  aw_valid_i, aw_id_i,
        output aw_ready_o,
        input  w_valid_i, w_last_i,
        output w_ready_o,
        output b_valid_o, b_id_o, b_resp_o,
        input  b_ready_i,
        output rom_req_o, rom_addr_o,
        input  rom_rdata_i
    );

    modport master (
        output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
        input  ar_ready_o,
        input  r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
        output r_ready_i,
        output aw_valid_i, aw_id_i,
        input  aw_ready_o,
        output w_valid_i, w_last_i,
        input  w_ready_o,
        input  b_valid_o, b_id_o, b_resp_o,
        output b_ready_i
    );

    modport rom (
        input  rom_req_o, rom_addr_o,
        output rom_rdata_i
    );
endinterface

// File: rtl/axi_bootrom_responder.sv
// AXI4 responder for the boot ROM: reads become one ROM access per beat, writes are drained and refused.
module axi_bootrom_responder #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned IdWidth     = 4,
    parameter logic [63:0] RomBase     = 64'h1_0000,
    parameter logic [63:0] RomSize     = 64'h1_0000,
    parameter int unsigned RomAddrBits = 13
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    axi_bootrom_responder_if.slave bus
);
    localparam logic [AddrWidth-1:0] RomBaseA = AddrWidth'(RomBase);
    localparam logic [AddrWidth-1:0] RomLastOff = AddrWidth'(RomSize - 64'd8);
    localparam logic [1:0] RespOkay = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_SEND} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} wr_state_t;

    rd_state_t rd_state, rd_state_next;
    wr_state_t wr_state, wr_state_next;

    logic [IdWidth-1:0]   rd_id;
    logic [AddrWidth-1:0] rd_addr;
    logic [7:0]           rd_len;
    logic [2:0]           rd_size;
    logic                 rd_fixed;
    logic                 rd_bad;
    logic [7:0]           beat_cnt;
    logic                 beat_err;
    logic [IdWidth-1:0]   wr_id;

    logic                 ar_hs, r_hs, aw_hs, rd_last;
    logic [AddrWidth-1:0] rom_off, step, next_addr;
    logic                 in_range;
    logic [DataWidth-1:0] beat_data;

    // Below-base addresses wrap to a huge offset, so one unsigned compare covers both bounds.
    assign rom_off   = rd_addr - RomBaseA;
    assign in_range  = (rom_off <= RomLastOff);
    assign step      = {{(AddrWidth-1){1'b0}}, 1'b1} << rd_size;
    assign next_addr = (rd_addr & ~(step - 1'b1)) + step;
    assign rd_last   = (beat_cnt == rd_len);
    assign beat_data = beat_err ? '0 : bus.rom_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
        end else begin
            rd_state <= rd_state_next;
            wr_state <= wr_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_id    <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_fixed <= 1'b0;
            rd_bad   <= 1'b0;
            beat_cnt <= '0;
            beat_err <= 1'b0;
            wr_id    <= '0;
        end else begin
            if (ar_hs) begin
                rd_id    <= bus.ar_id_i;
                rd_addr  <= bus.ar_addr_i;
                rd_len   <= bus.ar_len_i;
                rd_size  <= bus.ar_size_i;
                rd_fixed <= (bus.ar_burst_i == 2'b00);
                rd_bad   <= bus.ar_burst_i[1] | bus.ar_size_i[2];
                beat_cnt <= '0;
                beat_err <= 1'b0;
            end
            if (rd_state == R_REQ) begin
                beat_err <= rd_bad | ~in_range;
            end
            if (r_hs && !rd_last) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (!rd_fixed) begin
                    rd_addr <= next_addr;
                end
            end
            if (aw_hs) begin
                wr_id <= bus.aw_id_i;
            end
        end
    end

    // Read side: one ROM request per beat, then hold the beat until the initiator takes it.
    always_comb begin
        rd_state_next  = rd_state;
        ar_hs          = 1'b0;
        r_hs           = 1'b0;
        bus.ar_ready_o = 1'b0;
        bus.rom_req_o  = 1'b0;
        bus.rom_addr_o = '0;
        bus.r_valid_o  = 1'b0;
        bus.r_id_o     = '0;
        bus.r_data_o   = '0;
        bus.r_resp_o   = RespOkay;
        bus.r_last_o   = 1'b0;
        unique case (rd_state)
            R_IDLE: begin
                bus.ar_ready_o = 1'b1;
                ar_hs = bus.ar_valid_i;
                if (bus.ar_valid_i) begin
                    rd_state_next = R_REQ;
                end
            end
            R_REQ: begin
                if (!rd_bad && in_range) begin
                    bus.rom_req_o  = 1'b1;
                    bus.rom_addr_o = rom_off[RomAddrBits+2:3];
                end
                rd_state_next = R_SEND;
            end
            R_SEND: begin
                bus.r_valid_o = 1'b1;
                bus.r_id_o    = rd_id;
                bus.r_data_o  = beat_data;
                bus.r_resp_o  = beat_err ? RespSlverr : RespOkay;
                bus.r_last_o  = rd_last;
                r_hs = bus.r_ready_i;
                if (bus.r_ready_i) begin
                    rd_state_next = rd_last ? R_IDLE : R_REQ;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Write side: swallow the whole burst, then answer SLVERR.
    always_comb begin
        wr_state_next  = wr_state;
        aw_hs          = 1'b0;
        bus.aw_ready_o = 1'b0;
        bus.w_ready_o  = 1'b0;
        bus.b_valid_o  = 1'b0;
        bus.b_id_o     = '0;
        bus.b_resp_o   = RespOkay;
        unique case (wr_state)
            W_IDLE: begin
                bus.aw_ready_o = 1'b1;
                aw_hs = bus.aw_valid_i;
                if (bus.aw_valid_i) begin
                    wr_state_next = W_DRAIN;
                end
            end
            W_DRAIN: begin
                bus.w_ready_o = 1'b1;
                if (bus.w_valid_i && bus.w_last_i) begin
                    wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                bus.b_valid_o = 1'b1;
                bus.b_id_o    = wr_id;
                bus.b_resp_o  = RespSlverr;
                if (bus.b_ready_i) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_bootrom_responder.sv
// Directed bench for axi_bootrom_responder: table of read bursts plus write, stall and reset sequences.
module tb_axi_bootrom_responder;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    typedef struct {
        logic [3:0]        id;
        logic [63:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        int                stall_beat;
        int                stall_cyc;
        logic [3:0][63:0]  exp_data;
        logic [3:0][1:0]   exp_resp;
        int                exp_nreq;
        logic [3:0][12:0]  exp_rom;
    } rd_vec_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    rd_vec_t vecs[8];
    logic [63:0] rec_data[16];
    logic [1:0]  rec_resp[16];
    logic        rec_last[16];
    logic [3:0]  rec_id[16];
    int          first_seen[16];
    int          hs_cyc[16];
    logic [12:0] req_addr[16];
    int          n_req = 0;

    axi_bootrom_responder_if #(.AddrWidth(64), .DataWidth(64), .IdWidth(4), .RomAddrBits(13)) bus ();

    axi_bootrom_responder dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] rw(input logic [12:0] k);
        return 64'hA5A5_0000_0000_0000 | {51'd0, k};
    endfunction

    // Synchronous ROM: data appears the cycle after the request and holds.
    always @(posedge clk_i) begin
        if (bus.rom_req_o === 1'b1) begin
            bus.rom_rdata_i <= rw(bus.rom_addr_o);
        end
    end

    always @(negedge clk_i) begin
        if (bus.rom_req_o === 1'b1) begin
            if (n_req < 16) req_addr[n_req] = bus.rom_addr_o;
            n_req = n_req + 1;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic rd_vec_t mk(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst, input int sb, input int sc,
                                   input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                                   input logic [63:0] d3, input logic [7:0] resp, input int nreq,
                                   input logic [12:0] a0, input logic [12:0] a1, input logic [12:0] a2,
                                   input logic [12:0] a3);
        rd_vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.stall_beat = sb; v.stall_cyc = sc;
        v.exp_data = {d3, d2, d1, d0};
        v.exp_resp = resp;
        v.exp_nreq = nreq;
        v.exp_rom = {a3, a2, a1, a0};
        return v;
    endfunction

    // Called on a negedge; returns on a negedge after the last beat has been accepted.
    task automatic apply_stimulus(input rd_vec_t v, input string tag);
        int beats = 0;
        int cyc = 0;
        int stalled = 0;
        bit done = 0;
        n_req = 0;
        bus.r_ready_i = 1'b1;
        bus.ar_id_i = v.id; bus.ar_addr_i = v.addr; bus.ar_len_i = v.len;
        bus.ar_size_i = v.size; bus.ar_burst_i = v.burst; bus.ar_valid_i = 1'b1;
        check_output({tag, ".ar_ready"}, 64'(bus.ar_ready_o), 64'd1);
        @(posedge clk_i);
        for (int i = 0; i < 16; i++) first_seen[i] = -1;
        while (!done && cyc < 80) begin
            @(negedge clk_i);
            cyc++;
            bus.ar_valid_i = 1'b0;
            if (bus.r_valid_o === 1'b1 && beats < 16) begin
                if (first_seen[beats] < 0) first_seen[beats] = cyc;
                if (beats == v.stall_beat && stalled < v.stall_cyc) begin
                    bus.r_ready_i = 1'b0;
                    stalled++;
                    check_output($sformatf("%s.stall_data%0d", tag, stalled), bus.r_data_o, v.exp_data[beats]);
                    check_output($sformatf("%s.stall_last%0d", tag, stalled), 64'(bus.r_last_o),
                                 64'(beats == int'(v.len)));
                end else begin
                    bus.r_ready_i = 1'b1;
                    rec_data[beats] = bus.r_data_o; rec_resp[beats] = bus.r_resp_o;
                    rec_last[beats] = bus.r_last_o; rec_id[beats] = bus.r_id_o;
                    hs_cyc[beats] = cyc;
                    beats++;
                    if (bus.r_last_o === 1'b1) done = 1;
                end
            end
        end
        if (!done) report_timeout({tag, ".r_last"});
        @(negedge clk_i);
        check_output({tag, ".idle_after"}, 64'(bus.r_valid_o), 64'd0);
        check_output({tag, ".beats"}, 64'(beats), 64'(int'(v.len) + 1));
        for (int b = 0; b < beats && b < 4; b++) begin
            check_output($sformatf("%s.data[%0d]", tag, b), rec_data[b], v.exp_data[b]);
            check_output($sformatf("%s.resp[%0d]", tag, b), 64'(rec_resp[b]), 64'(v.exp_resp[b]));
            check_output($sformatf("%s.last[%0d]", tag, b), 64'(rec_last[b]), 64'(b == int'(v.len)));
            check_output($sformatf("%s.id[%0d]", tag, b), 64'(rec_id[b]), 64'(v.id));
            check_output($sformatf("%s.lat[%0d]", tag, b), 64'(first_seen[b] - (b == 0 ? 0 : hs_cyc[b-1])), 64'd2);
        end
        check_output({tag, ".nreq"}, 64'(n_req), 64'(v.exp_nreq));
        for (int i = 0; i < n_req && i < 4; i++) begin
            check_output($sformatf("%s.rom_addr[%0d]", tag, i), 64'(req_addr[i]), 64'(v.exp_rom[i]));
        end
    endtask

    task automatic write_sequence();
        int wait_cyc;
        bus.w_valid_i = 1'b1; bus.w_last_i = 1'b0; bus.b_ready_i = 1'b0;
        check_output("w.early_w_ready", 64'(bus.w_ready_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        bus.aw_id_i = 4'd9; bus.aw_valid_i = 1'b1;
        check_output("w.aw_ready", 64'(bus.aw_ready_o), 64'd1);
        check_output("w.w_ready_before_aw", 64'(bus.w_ready_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        bus.aw_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.w_valid_i = 1'b1; bus.w_last_i = (i == 3);
            wait_cyc = 0;
            while (bus.w_ready_o !== 1'b1 && wait_cyc < 10) begin
                @(negedge clk_i);
                wait_cyc++;
            end
            if (wait_cyc >= 10) report_timeout("w.w_ready");
            @(posedge clk_i);
            @(negedge clk_i);
        end
        bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("w.b_valid%0d", i), 64'(bus.b_valid_o), 64'd1);
            check_output($sformatf("w.b_id%0d", i), 64'(bus.b_id_o), 64'd9);
            check_output($sformatf("w.b_resp%0d", i), 64'(bus.b_resp_o), 64'd2);
            @(negedge clk_i);
        end
        bus.b_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.b_ready_i = 1'b0;
        check_output("w.b_valid_after", 64'(bus.b_valid_o), 64'd0);
        check_output("w.aw_ready_after", 64'(bus.aw_ready_o), 64'd1);
    endtask

    task automatic reset_mid_burst();
        int beats = 0;
        int cyc = 0;
        bus.r_ready_i = 1'b1;
        bus.ar_id_i = 4'd3; bus.ar_addr_i = 64'h1_0000; bus.ar_len_i = 8'd7;
        bus.ar_size_i = 3'd3; bus.ar_burst_i = INCR; bus.ar_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.ar_valid_i = 1'b0;
        while (cyc < 40 && !(bus.r_valid_o === 1'b1 && beats == 2)) begin
            if (bus.r_valid_o === 1'b1) beats++;
            @(negedge clk_i);
            cyc++;
        end
        if (cyc >= 40) report_timeout("rst.beat2");
        check_output("rst.beat2_data", bus.r_data_o, rw(13'd2));
        rst_ni = 1'b0;
        #1;
        check_output("rst.r_valid", 64'(bus.r_valid_o), 64'd0);
        check_output("rst.r_last", 64'(bus.r_last_o), 64'd0);
        check_output("rst.rom_req", 64'(bus.rom_req_o), 64'd0);
        check_output("rst.ar_ready", 64'(bus.ar_ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_output("rst.r_valid_after", 64'(bus.r_valid_o), 64'd0);
        check_output("rst.ar_ready_after", 64'(bus.ar_ready_o), 64'd1);
        apply_stimulus(vecs[0], "rst.v0");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.ar_valid_i = 1'b0; bus.ar_id_i = '0; bus.ar_addr_i = '0; bus.ar_len_i = '0;
        bus.ar_size_i = '0; bus.ar_burst_i = '0; bus.r_ready_i = 1'b0;
        bus.aw_valid_i = 1'b0; bus.aw_id_i = '0; bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0;
        bus.b_ready_i = 1'b0;

        vecs[0] = mk(4'd3, 64'h1_0000, 8'd3, 3'd3, INCR, -1, 0, rw(0), rw(1), rw(2), rw(3),
                     8'b00_00_00_00, 4, 13'd0, 13'd1, 13'd2, 13'd3);
        vecs[1] = mk(4'd1, 64'h1_FFF0, 8'd3, 3'd3, INCR, -1, 0, rw(13'h1FFE), rw(13'h1FFF), 64'd0, 64'd0,
                     8'b10_10_00_00, 2, 13'h1FFE, 13'h1FFF, 13'd0, 13'd0);
        vecs[2] = mk(4'd2, 64'h8000_0000, 8'd0, 3'd3, INCR, -1, 0, 64'd0, 64'd0, 64'd0, 64'd0,
                     8'b00_00_00_10, 0, 13'd0, 13'd0, 13'd0, 13'd0);
        vecs[3] = mk(4'd5, 64'h1_0000, 8'd1, 3'd3, WRAP, -1, 0, 64'd0, 64'd0, 64'd0, 64'd0,
                     8'b00_00_10_10, 0, 13'd0, 13'd0, 13'd0, 13'd0);
        vecs[4] = mk(4'd4, 64'h1_0008, 8'd2, 3'd3, FIXED, 1, 5, rw(1), rw(1), rw(1), 64'd0,
                     8'b00_00_00_00, 3, 13'd1, 13'd1, 13'd1, 13'd0);
        vecs[5] = mk(4'd7, 64'h1_0010, 8'd2, 3'd2, INCR, -1, 0, rw(2), rw(2), rw(3), 64'd0,
                     8'b00_00_00_00, 3, 13'd2, 13'd2, 13'd3, 13'd0);
        vecs[6] = mk(4'd6, 64'h1_0000, 8'd0, 3'd4, INCR, -1, 0, 64'd0, 64'd0, 64'd0, 64'd0,
                     8'b00_00_00_10, 0, 13'd0, 13'd0, 13'd0, 13'd0);
        vecs[7] = mk(4'd8, 64'h0_FFF8, 8'd1, 3'd3, INCR, -1, 0, 64'd0, rw(0), 64'd0, 64'd0,
                     8'b00_00_00_10, 1, 13'd0, 13'd0, 13'd0, 13'd0);

        repeat (3) @(negedge clk_i);
        check_output("reset.ar_ready", 64'(bus.ar_ready_o), 64'd1);
        check_output("reset.aw_ready", 64'(bus.aw_ready_o), 64'd1);
        check_output("reset.r_valid", 64'(bus.r_valid_o), 64'd0);
        check_output("reset.w_ready", 64'(bus.w_ready_o), 64'd0);
        check_output("reset.b_valid", 64'(bus.b_valid_o), 64'd0);
        check_output("reset.rom_req", 64'(bus.rom_req_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i], $sformatf("v%0d", i));
        end

        fork
            write_sequence();
            begin
                @(negedge clk_i);
                apply_stimulus(vecs[0], "wr.v0");
            end
        join
        @(negedge clk_i);

        reset_mid_burst();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
